// File: rtl/datapath_mem_hs_if.sv
// Datapath-to-memory-bridge handshake: mem_req holds address/data/direction until a one-cycle mem_ack.
// mem_rdata is only meaningful in the cycle mem_ack is high.
interface datapath_mem_hs_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/datapath_mem_hs.sv
// LC-3-style datapath (regfile, ALU, address adder, NZP/BEN) with a req/ack memory port; loads land on the next edge.
// An access takes >= 2 cycles MEM_START->MEM_R; mem_req doubles as busy and blocks LD_MAR/LD_MDR/MEM_START.
module datapath_mem_hs #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [6:0]        LD,
  input  logic [3:0]        GATE,
  input  logic [1:0]        PCMUX,
  input  logic              DRMUX,
  input  logic              SR1MUX,
  input  logic              SR2MUX,
  input  logic              ADDR1MUX,
  input  logic [1:0]        ADDR2MUX,
  input  logic [1:0]        ALUK,
  input  logic              MEM_START,
  input  logic              MEM_WE,
  datapath_mem_hs_if.master mem,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [15:0]       IR,
  output logic [DATA_W-1:0] PC,
  output logic              BEN,
  output logic [2:0]        NZP,
  output logic              MEM_R,
  output logic              BUS_ERR,
  output logic              MEM_ERR
);
  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
  assign {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc} = LD;

  logic [DATA_W-1:0] rf [8];
  logic [2:0]        dr, sr1_sel;
  logic [DATA_W-1:0] sr1, sr2, alu, addr1, addr2, adder, bus;
  logic [DATA_W-1:0] imm5, off6, off9, off11;
  logic              multi_gate;

  assign imm5  = {{(DATA_W-5){IR[4]}},   IR[4:0]};
  assign off6  = {{(DATA_W-6){IR[5]}},   IR[5:0]};
  assign off9  = {{(DATA_W-9){IR[8]}},   IR[8:0]};
  assign off11 = {{(DATA_W-11){IR[10]}}, IR[10:0]};

  assign dr      = DRMUX  ? 3'd7 : IR[11:9];
  assign sr1_sel = SR1MUX ? IR[8:6] : IR[11:9];
  assign sr1     = rf[sr1_sel];
  assign sr2     = SR2MUX ? imm5 : rf[IR[2:0]];
  assign addr1   = ADDR1MUX ? sr1 : PC;
  assign adder   = addr1 + addr2;

  always_comb begin
    case (ADDR2MUX)
      2'b00:   addr2 = '0;
      2'b01:   addr2 = off6;
      2'b10:   addr2 = off9;
      default: addr2 = off11;
    endcase
  end

  always_comb begin
    case (ALUK)
      2'b00:   alu = sr1 + sr2;
      2'b01:   alu = sr1 & sr2;
      2'b10:   alu = ~sr1;
      default: alu = sr1;
    endcase
  end

  // Contention drives zero rather than a wired-OR of sources.
  always_comb begin
    case (GATE)
      4'b1000: bus = PC;
      4'b0100: bus = MDR;
      4'b0010: bus = alu;
      4'b0001: bus = adder;
      default: bus = '0;
    endcase
  end
  assign multi_gate = (GATE & (GATE - 4'd1)) != 4'd0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PC      <= '0;
      IR      <= '0;
      MAR     <= '0;
      NZP     <= 3'b010;
      BEN     <= 1'b0;
      BUS_ERR <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (ld_pc) begin
        case (PCMUX)
          2'b00:   PC <= PC + DATA_W'(1);
          2'b01:   PC <= bus;
          2'b10:   PC <= adder;
          default: PC <= PC;
        endcase
      end
      if (ld_ir) IR <= bus[15:0];
      if (ld_mar && !mem.mem_req) MAR <= bus[ADDR_W-1:0];
      if (ld_reg) rf[dr] <= bus;
      if (ld_cc) NZP <= bus[DATA_W-1] ? 3'b100 : ((bus == '0) ? 3'b010 : 3'b001);
      if (ld_ben) BEN <= (IR[11] & NZP[2]) | (IR[10] & NZP[1]) | (IR[9] & NZP[0]);
      if (multi_gate) BUS_ERR <= 1'b1;
    end
  end

  // MDR lives here: it is written either from the bus (idle) or by a completed read.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      MDR           <= '0;
      MEM_R         <= 1'b0;
      MEM_ERR       <= 1'b0;
    end else begin
      MEM_R <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_mdr) MDR <= bus;
          if (MEM_START) begin
            mem.mem_addr  <= MAR;
            mem.mem_wdata <= MDR;
            mem.mem_we    <= MEM_WE;
            mem.mem_req   <= 1'b1;
            cnt           <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            MEM_R       <= 1'b1;
            state       <= IDLE;
            if (!mem.mem_we) MDR <= mem.mem_rdata;
          end else if (cnt == CNT_LAST) begin
            mem.mem_req <= 1'b0;
            MEM_R       <= 1'b1;
            MEM_ERR     <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end
endmodule
